madd_sched: RTL



---
 rtl/madd_pkg.sv | 14 +
 rtl/madd_resp_fifo.sv | 46 ++++
 rtl/madd_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/madd_pkg.sv
// Shared definitions for the MADD scheduler: default widths and response/requester types.
package madd_pkg;

    localparam int MADD_W   = 32;
    localparam int MADD_LAT = 1;

    typedef logic req_id_t;

    typedef struct packed {
        req_id_t             id;
        logic [MADD_W-1:0]   z;
    } resp_entry_t;

endpackage

// File: rtl/madd_resp_fifo.sv
// Synchronous response FIFO with occupancy count; head is read combinationally from storage.
module madd_resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/madd_sched.sv
// Round-robin scheduler sharing one MADD unit between two requesters, with
// credit-protected tagged responses and per-requester accumulate mode.
module madd_sched
    import madd_pkg::*;
#(
    parameter int W     = MADD_W,
    parameter int LAT   = MADD_LAT,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,
    input  logic         req0_acc,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,
    input  logic         req1_acc,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_z,
    output logic         resp_id,
    output logic [W-1:0] madd_a,
    output logic [W-1:0] madd_b,
    output logic [W-1:0] madd_c,
    output logic         madd_enab,
    output logic         madd_enc,
    input  logic [W-1:0] madd_z
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  inflight_total;
    logic [LAT-1:0] pipe_valid;
    logic [LAT-1:0] pipe_id;
    logic           prio;
    logic [W-1:0]   acc0;
    logic [W-1:0]   acc1;
    logic [W-1:0]   hold_a;
    logic [W-1:0]   hold_b;
    logic [W-1:0]   hold_c;

    logic           credit_ok;
    logic           inflight0;
    logic           inflight1;
    logic           elig0;
    logic           elig1;
    logic           grant0;
    logic           grant1;
    logic           issue;
    req_id_t        gid;
    logic           push;
    req_id_t        push_id;
    logic           pop;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   sel_c;
    logic [W:0]     fifo_head;

    // Every issued op owns a FIFO slot from issue until it is popped, so a push can never be refused.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_total}) < (CW+1)'(DEPTH);
    assign inflight0 = |(pipe_valid & ~pipe_id);
    assign inflight1 = |(pipe_valid & pipe_id);

    assign elig0 = !RST && req0_valid && credit_ok && !(req0_acc && inflight0);
    assign elig1 = !RST && req1_valid && credit_ok && !(req1_acc && inflight1);

    // prio names the requester that wins a tie; it moves to the other side after each grant.
    assign grant0 = elig0 && (!elig1 || !prio);
    assign grant1 = elig1 && (!elig0 || prio);
    assign issue  = grant0 || grant1;
    assign gid    = grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_a = grant1 ? req1_a : req0_a;
    assign sel_b = grant1 ? req1_b : req0_b;
    assign sel_c = grant1 ? (req1_acc ? acc1 : req1_c) : (req0_acc ? acc0 : req0_c);

    assign madd_a    = issue ? sel_a : hold_a;
    assign madd_b    = issue ? sel_b : hold_b;
    assign madd_c    = issue ? sel_c : hold_c;
    assign madd_enab = issue;
    assign madd_enc  = issue;

    // The oldest pipe stage marks the cycle in which madd_z belongs to that op.
    assign push    = pipe_valid[LAT-1];
    assign push_id = pipe_id[LAT-1];

    assign resp_valid = (fifo_count != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_id    = fifo_head[W];
    assign resp_z     = fifo_head[W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_valid     <= '0;
            pipe_id        <= '0;
            prio           <= 1'b0;
            acc0           <= '0;
            acc1           <= '0;
            hold_a         <= '0;
            hold_b         <= '0;
            hold_c         <= '0;
            inflight_total <= '0;
        end else begin
            pipe_valid[0] <= issue;
            pipe_id[0]    <= gid;
            for (int s = 1; s < LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_id[s]    <= pipe_id[s-1];
            end
            if (issue) begin
                prio   <= ~gid;
                hold_a <= sel_a;
                hold_b <= sel_b;
                hold_c <= sel_c;
            end
            if (push && (push_id == 1'b0)) begin
                acc0 <= madd_z;
            end
            if (push && (push_id == 1'b1)) begin
                acc1 <= madd_z;
            end
            case ({issue, push})
                2'b10:   inflight_total <= inflight_total + CW'(1);
                2'b01:   inflight_total <= inflight_total - CW'(1);
                default: inflight_total <= inflight_total;
            endcase
        end
    end

    madd_resp_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data ({push_id, madd_z}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule
